// File: rtl/inst_decode_queue.sv
// inst_decode_queue: circular FIFO of raw RV32I {inst, pc} pairs feeding one
// registered decode stage. Total capacity is DEPTH+1 (FIFO plus output stage).
// A push into an empty queue lands directly in the output stage (1-cycle latency).
// Optional feature: define PERF_CNT_EN to add JALR and branch dispatch counters.
module inst_decode_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [5:0]  out_openum,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic        out_is_jump,
  output logic        out_is_branch,
  output logic        out_is_store
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] perf_jalr_cnt,
  output logic [31:0] perf_branch_cnt
`endif
);

  localparam logic [5:0] OPENUM_NOP   = 6'd0;
  localparam logic [5:0] OPENUM_LUI   = 6'd1;
  localparam logic [5:0] OPENUM_AUIPC = 6'd2;
  localparam logic [5:0] OPENUM_JAL   = 6'd3;
  localparam logic [5:0] OPENUM_JALR  = 6'd4;
  localparam logic [5:0] OPENUM_BEQ   = 6'd5;
  localparam logic [5:0] OPENUM_BNE   = 6'd6;
  localparam logic [5:0] OPENUM_BLT   = 6'd7;
  localparam logic [5:0] OPENUM_BGE   = 6'd8;
  localparam logic [5:0] OPENUM_BLTU  = 6'd9;
  localparam logic [5:0] OPENUM_BGEU  = 6'd10;
  localparam logic [5:0] OPENUM_LB    = 6'd11;
  localparam logic [5:0] OPENUM_LH    = 6'd12;
  localparam logic [5:0] OPENUM_LW    = 6'd13;
  localparam logic [5:0] OPENUM_LBU   = 6'd14;
  localparam logic [5:0] OPENUM_LHU   = 6'd15;
  localparam logic [5:0] OPENUM_SB    = 6'd16;
  localparam logic [5:0] OPENUM_SH    = 6'd17;
  localparam logic [5:0] OPENUM_SW    = 6'd18;
  localparam logic [5:0] OPENUM_ADDI  = 6'd19;
  localparam logic [5:0] OPENUM_SLTI  = 6'd20;
  localparam logic [5:0] OPENUM_SLTIU = 6'd21;
  localparam logic [5:0] OPENUM_XORI  = 6'd22;
  localparam logic [5:0] OPENUM_ORI   = 6'd23;
  localparam logic [5:0] OPENUM_ANDI  = 6'd24;
  localparam logic [5:0] OPENUM_SLLI  = 6'd25;
  localparam logic [5:0] OPENUM_SRLI  = 6'd26;
  localparam logic [5:0] OPENUM_SRAI  = 6'd27;
  localparam logic [5:0] OPENUM_ADD   = 6'd28;
  localparam logic [5:0] OPENUM_SUB   = 6'd29;
  localparam logic [5:0] OPENUM_SLL   = 6'd30;
  localparam logic [5:0] OPENUM_SLT   = 6'd31;
  localparam logic [5:0] OPENUM_SLTU  = 6'd32;
  localparam logic [5:0] OPENUM_XOR   = 6'd33;
  localparam logic [5:0] OPENUM_SRL   = 6'd34;
  localparam logic [5:0] OPENUM_SRA   = 6'd35;
  localparam logic [5:0] OPENUM_OR    = 6'd36;
  localparam logic [5:0] OPENUM_AND   = 6'd37;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [5:0]  openum;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_jump;
    logic        is_branch;
    logic        is_store;
  } dec_t;

  // Pure RV32I decode; anything unrecognised collapses to an all-zero NOP.
  function automatic dec_t decode(input logic [31:0] inst);
    dec_t        d;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    f3    = inst[14:12];
    alt   = (inst[31:25] == 7'b0100000);
    imm_i = {{20{inst[31]}}, inst[31:20]};
    imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    imm_u = {inst[31:12], 12'b0};
    d        = '0;
    d.openum = OPENUM_NOP;
    d.rd     = inst[11:7];
    d.rs1    = inst[19:15];
    d.rs2    = inst[24:20];
    case (inst[6:0])
      OPC_LUI:   begin d.openum = OPENUM_LUI;   d.imm = imm_u; end
      OPC_AUIPC: begin d.openum = OPENUM_AUIPC; d.imm = imm_u; end
      OPC_JAL:   begin d.openum = OPENUM_JAL;   d.imm = imm_j; d.is_jump = 1'b1; end
      OPC_JALR: begin
        if (f3 == 3'd0) begin
          d.openum  = OPENUM_JALR;
          d.imm     = imm_i;
          d.is_jump = 1'b1;
        end
      end
      OPC_BRANCH: begin
        d.rd        = 5'd0;
        d.imm       = imm_b;
        d.is_jump   = 1'b1;
        d.is_branch = 1'b1;
        case (f3)
          3'd0:    d.openum = OPENUM_BEQ;
          3'd1:    d.openum = OPENUM_BNE;
          3'd4:    d.openum = OPENUM_BLT;
          3'd5:    d.openum = OPENUM_BGE;
          3'd6:    d.openum = OPENUM_BLTU;
          3'd7:    d.openum = OPENUM_BGEU;
          default: d.openum = OPENUM_NOP;
        endcase
      end
      OPC_LOAD: begin
        d.imm = imm_i;
        case (f3)
          3'd0:    d.openum = OPENUM_LB;
          3'd1:    d.openum = OPENUM_LH;
          3'd2:    d.openum = OPENUM_LW;
          3'd4:    d.openum = OPENUM_LBU;
          3'd5:    d.openum = OPENUM_LHU;
          default: d.openum = OPENUM_NOP;
        endcase
      end
      OPC_STORE: begin
        d.rd       = 5'd0;
        d.imm      = imm_s;
        d.is_store = 1'b1;
        case (f3)
          3'd0:    d.openum = OPENUM_SB;
          3'd1:    d.openum = OPENUM_SH;
          3'd2:    d.openum = OPENUM_SW;
          default: d.openum = OPENUM_NOP;
        endcase
      end
      OPC_OPIMM: begin
        d.imm = imm_i;
        case (f3)
          3'd0: d.openum = OPENUM_ADDI;
          3'd1: begin d.openum = OPENUM_SLLI; d.imm = {27'd0, inst[24:20]}; end
          3'd2: d.openum = OPENUM_SLTI;
          3'd3: d.openum = OPENUM_SLTIU;
          3'd4: d.openum = OPENUM_XORI;
          3'd5: begin
            d.openum = alt ? OPENUM_SRAI : OPENUM_SRLI;
            d.imm    = {27'd0, inst[24:20]};
          end
          3'd6: d.openum = OPENUM_ORI;
          default: d.openum = OPENUM_ANDI;
        endcase
      end
      OPC_OP: begin
        case (f3)
          3'd0: d.openum = alt ? OPENUM_SUB : OPENUM_ADD;
          3'd1: d.openum = OPENUM_SLL;
          3'd2: d.openum = OPENUM_SLT;
          3'd3: d.openum = OPENUM_SLTU;
          3'd4: d.openum = OPENUM_XOR;
          3'd5: d.openum = alt ? OPENUM_SRA : OPENUM_SRL;
          3'd6: d.openum = OPENUM_OR;
          default: d.openum = OPENUM_AND;
        endcase
      end
      default: d.openum = OPENUM_NOP;
    endcase
    if (d.openum == OPENUM_NOP) begin
      d = '0;
    end
    return d;
  endfunction

  logic [63:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;

  logic        push;
  logic        load_slot;
  logic        fifo_empty;
  logic        fifo_pop;
  logic        bypass;
  logic        fifo_wr;
  logic        load_p0;
  logic [31:0] src_inst_p0;
  logic [31:0] src_pc_p0;
  dec_t        dec_p0;

  // ---- stage 0: FIFO control, source select and decode ----
  assign in_ready   = (count != FULL_CNT);
  assign push       = in_valid && in_ready && !flush;
  assign load_slot  = !out_valid || out_ready;
  assign fifo_empty = (count == '0);
  assign fifo_pop   = load_slot && !fifo_empty && !flush;
  assign bypass     = load_slot && fifo_empty && push;
  assign fifo_wr    = push && !bypass;
  assign load_p0    = fifo_pop || bypass;

  assign src_inst_p0 = fifo_empty ? in_inst : mem[rd_ptr][63:32];
  assign src_pc_p0   = fifo_empty ? in_pc   : mem[rd_ptr][31:0];
  assign dec_p0      = decode(src_inst_p0);

  // FIFO payload storage; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem[wr_ptr] <= {in_inst, in_pc};
    end
  end

  // FIFO pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- stage 1: registered decode output ----
  // Output stage loads the next decoded entry whenever it is free or draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_openum    <= OPENUM_NOP;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_is_jump   <= 1'b0;
      out_is_branch <= 1'b0;
      out_is_store  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_p0) begin
      out_valid     <= 1'b1;
      out_pc        <= src_pc_p0;
      out_imm       <= dec_p0.imm;
      out_openum    <= dec_p0.openum;
      out_rd        <= dec_p0.rd;
      out_rs1       <= dec_p0.rs1;
      out_rs2       <= dec_p0.rs2;
      out_is_jump   <= dec_p0.is_jump;
      out_is_branch <= dec_p0.is_branch;
      out_is_store  <= dec_p0.is_store;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  // Dispatch counters; they survive flush and only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_jalr_cnt   <= '0;
      perf_branch_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_openum == OPENUM_JALR) perf_jalr_cnt <= perf_jalr_cnt + 32'd1;
      if (out_is_branch) perf_branch_cnt <= perf_branch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_decode_queue.sv
// Scoreboard bench for inst_decode_queue: a driver issues stimulus and queues
// expected decodes from an arithmetic reference model; a negedge monitor
// compares whatever the DUT presents against the queue head.
module tb_inst_decode_queue;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [5:0]  out_openum;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_is_jump, out_is_branch, out_is_store;
`ifdef PERF_CNT_EN
  logic [31:0] perf_jalr_cnt, perf_branch_cnt;
`endif

  inst_decode_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
`ifdef PERF_CNT_EN
    .perf_jalr_cnt(perf_jalr_cnt),
    .perf_branch_cnt(perf_branch_cnt),
`endif
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_openum(out_openum), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_is_jump(out_is_jump), .out_is_branch(out_is_branch), .out_is_store(out_is_store)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        j;
    logic        b;
    logic        s;
  } exp_t;

  exp_t exp_q[$];
  int   n_items;
  int   total;
  int   bad;
  int   perf_j_m;
  int   perf_b_m;
  bit   pending_clear;

  int br_tab  [8] = '{5, 6, -1, -1, 7, 8, 9, 10};
  int ld_tab  [8] = '{11, 12, 13, -1, 14, 15, -1, -1};
  int st_tab  [8] = '{16, 17, 18, -1, -1, -1, -1, -1};
  int opi_tab [8] = '{19, 25, 20, 21, 22, 26, 23, 24};
  int op_tab  [8] = '{28, 30, 31, 32, 33, 34, 36, 37};

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, want, $time);
    end
  endfunction

  function automatic logic [31:0] sext(input longint v, input int bits);
    longint r;
    r = v;
    if (r >= (longint'(1) << (bits - 1))) r = r - (longint'(1) << bits);
    return r[31:0];
  endfunction

  // Reference decode built from field arithmetic and opcode tables.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t        e;
    int          op;
    bit          rd_zero;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    longint      i_raw, s_raw, b_raw, j_raw;
    e = '0;
    e.pc = pc;
    op = -1;
    rd_zero = 0;
    opc = inst[6:0];
    f3  = inst[14:12];
    f7  = inst[31:25];
    i_raw = longint'(inst[31:20]);
    s_raw = longint'(inst[31:25]) * 32 + longint'(inst[11:7]);
    b_raw = longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048
          + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
    j_raw = longint'(inst[31]) * 1048576 + longint'(inst[19:12]) * 4096
          + longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2;
    case (opc)
      7'h37, 7'h17: begin op = (opc == 7'h37) ? 1 : 2; e.imm = 32'(inst[31:12]) << 12; end
      7'h6F: begin op = 3; e.j = 1; e.imm = sext(j_raw, 21); end
      7'h67: if (f3 == 0) begin op = 4; e.j = 1; e.imm = sext(i_raw, 12); end
      7'h63: begin op = br_tab[f3]; e.j = 1; e.b = 1; e.imm = sext(b_raw, 13); rd_zero = 1; end
      7'h03: begin op = ld_tab[f3]; e.imm = sext(i_raw, 12); end
      7'h23: begin op = st_tab[f3]; e.s = 1; e.imm = sext(s_raw, 12); rd_zero = 1; end
      7'h13: begin
        op = opi_tab[f3];
        if (f3 == 5 && f7 == 7'h20) op = 27;
        e.imm = (f3 == 1 || f3 == 5) ? 32'(inst[24:20]) : sext(i_raw, 12);
      end
      7'h33: begin
        op = op_tab[f3];
        if (f7 == 7'h20 && f3 == 0) op = 29;
        if (f7 == 7'h20 && f3 == 5) op = 35;
      end
      default: op = -1;
    endcase
    if (op < 0) begin
      e = '0;
      e.pc = pc;
      return e;
    end
    e.op  = 6'(op);
    e.rd  = rd_zero ? 5'd0 : inst[11:7];
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    return e;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  opc;
    int          k;
    logic [6:0]  f7;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: opc = 7'h37;
      1: opc = 7'h17;
      2: opc = 7'h6F;
      3: opc = 7'h67;
      4: opc = 7'h63;
      5: opc = 7'h03;
      6: opc = 7'h23;
      7: opc = 7'h13;
      8: opc = 7'h33;
      default: opc = r[6:0];
    endcase
    r[6:0] = opc;
    if (k == 3 && $urandom_range(0, 3) != 0) r[14:12] = 3'd0;
    if (k == 7 || k == 8) begin
      case ($urandom_range(0, 2))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        default: f7 = r[31:25];
      endcase
      r[31:25] = f7;
    end
    return r;
  endfunction

  // One clock of stimulus: drive, predict handshakes, then check occupancy view.
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit acc, pop;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    acc = v && (n_items <= DEPTH) && !fl;
    pop = ordy && (n_items > 0) && !fl;
    if (fl) begin
      n_items = 0;
      pending_clear = 1;
    end else begin
      if (acc) exp_q.push_back(ref_decode(inst, pc));
      n_items = n_items + int'(acc) - int'(pop);
    end
    @(posedge clk);
    #2;
    if (pending_clear) begin
      exp_q.delete();
      pending_clear = 0;
    end
    chk("in_ready", in_ready, n_items <= DEPTH);
    chk("out_valid", out_valid, n_items > 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    n_items = 0;
    perf_j_m = 0;
    perf_b_m = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_openum", out_openum, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
`ifdef PERF_CNT_EN
    chk("rst_perf_jalr", perf_jalr_cnt, 0);
    chk("rst_perf_branch", perf_branch_cnt, 0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: whatever the output stage shows must be the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", out_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q[0];
        chk("pc", out_pc, e.pc);
        chk("openum", out_openum, e.op);
        chk("imm", out_imm, e.imm);
        chk("rd", out_rd, e.rd);
        chk("rs1", out_rs1, e.rs1);
        chk("rs2", out_rs2, e.rs2);
        chk("flags", {out_is_jump, out_is_branch, out_is_store}, {e.j, e.b, e.s});
        if (out_ready && !flush) begin
          void'(exp_q.pop_front());
          if (e.op == 6'd4) perf_j_m++;
          if (e.b) perf_b_m++;
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    bit v, o, f;
    total = 0; bad = 0; n_items = 0; pending_clear = 0;
    perf_j_m = 0; perf_b_m = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_openum", out_openum, 0);
    chk("reset_rd", out_rd, 0);
    chk("reset_imm", out_imm, 0);
    rst = 1'b0;

    // Directed decodes with literal expectations.
    cycle(1, 32'h0050_0093, 32'h0, 1, 0);
    chk("addi_valid", out_valid, 1);
    chk("addi_openum", out_openum, 19);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_imm", out_imm, 32'h5);
    cycle(1, 32'hFE00_0EE3, 32'h100, 1, 0);
    chk("beq_openum", out_openum, 5);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_rd", out_rd, 0);
    chk("beq_jump", out_is_jump, 1);
    chk("beq_branch", out_is_branch, 1);
    cycle(1, 32'h4030_D093, 32'h104, 1, 0);
    chk("srai_openum", out_openum, 27);
    chk("srai_rd", out_rd, 1);
    chk("srai_rs1", out_rs1, 1);
    chk("srai_imm", out_imm, 32'h3);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Fill to capacity with a stalled consumer, then drain in order.
    for (int i = 0; i < 6; i++) cycle(1, 32'h0000_0013 | (32'(i + 1) << 7), 32'h200 + 32'(i * 4), 0, 0);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < 7; i++) cycle(0, 32'h0, 32'h0, 1, 0);
    chk("drained_valid", out_valid, 0);

    // Flush with a queue of three and a concurrent push.
    for (int i = 0; i < 3; i++) cycle(1, 32'h0010_0093, 32'h300 + 32'(i * 4), 0, 0);
    cycle(1, 32'h0020_0113, 32'h400, 0, 1);
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    cycle(0, 32'h0, 32'h0, 1, 0);
    cycle(0, 32'h0, 32'h0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 60);
      o = ($urandom_range(0, 99) < 55);
      f = ($urandom_range(0, 99) < 3);
      if (f) o = 0;
      pc = $urandom & 32'hFFFF_FFFC;
      cycle(v, gen_inst(), pc, o, f);
    end
    for (int i = 0; i < 3 * DEPTH + 5; i++) begin
      if (n_items > 0) cycle(0, 32'h0, 32'h0, 1, 0);
    end
    chk("drain_empty", exp_q.size(), 0);
    chk("drain_valid", out_valid, 0);
`ifdef PERF_CNT_EN
    chk("perf_jalr_rand", perf_jalr_cnt, perf_j_m);
    chk("perf_branch_rand", perf_branch_cnt, perf_b_m);
`endif

    // Reset in the middle of a transfer discards everything.
    for (int i = 0; i < 3; i++) cycle(1, 32'h0000_80E7, 32'h500 + 32'(i * 4), 0, 0);
    do_reset();
    cycle(0, 32'h0, 32'h0, 1, 0);
    chk("post_rst_ready", in_ready, 1);

    // Two JALR and three branches dispatched.
    cycle(1, 32'h0000_80E7, 32'h600, 1, 0);
    cycle(1, 32'hFE00_0EE3, 32'h604, 1, 0);
    cycle(1, 32'h0000_80E7, 32'h608, 1, 0);
    cycle(1, 32'hFE00_0EE3, 32'h60C, 1, 0);
    cycle(1, 32'hFE00_0EE3, 32'h610, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 32'h0, 32'h0, 1, 0);
`ifdef PERF_CNT_EN
    chk("perf_jalr", perf_jalr_cnt, 2);
    chk("perf_branch", perf_branch_cnt, 3);
`endif
    cycle(1, 32'hFE00_0EE3, 32'h700, 0, 0);
    cycle(1, 32'h0000_80E7, 32'h704, 0, 0);
    do_reset();
    cycle(0, 32'h0, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
